// File: rtl/axi_pkg.sv
// Shared AXI3 constants, request payload, FSM encodings and burst address stepping
// for the SRAM slave model.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_STRB_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Latched AR/AW request
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ax_req_t;

  // FIXED holds the address; INCR, WRAP and reserved all step by the beat size
  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (AXI_ADDR_W'(1) << size);
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-addressed RAM: one registered read port, one byte-enabled write port, no reset.
module axi_sram_mem #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_strb
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  // Read sees the pre-write contents on a same-cycle collision
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave memory model: independent read and write FSMs in front of a word RAM,
// with a configurable idle delay before every R beat.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned READ_DELAY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam bit         NO_DELAY = (READ_DELAY == 0);
  localparam logic [3:0] DLY_LAST = 4'(NO_DELAY ? 0 : READ_DELAY - 1);

  rd_state_e r_state;
  ax_req_t   r_req;
  logic [7:0]  r_beat;
  logic [3:0]  r_cnt;
  logic        r_ok;
  logic [31:0] r_addr_nxt;

  wr_state_e w_state;
  ax_req_t   w_req;
  logic [7:0]  w_beat;
  logic [31:0] w_addr_nxt;

  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_rd_addr;
  logic [31:0]          mem_rd_data;
  logic                 mem_wr_en;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign r_addr_nxt = next_addr(r_req.addr, r_req.size, r_req.burst);
  assign w_addr_nxt = next_addr(w_req.addr, w_req.size, w_req.burst);

  assign rid   = r_req.id;
  assign bid   = w_req.id;
  // Error reads and reset both present zero data
  assign rdata = r_ok ? mem_rd_data : 32'd0;

  // Fetch the beat's word on the same edge that raises rvalid
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = r_req.addr[ADDR_BITS+1:2];
    case (r_state)
      R_IDLE: if (arready && arvalid && NO_DELAY) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = araddr[ADDR_BITS+1:2];
      end
      R_WAIT: if (r_cnt == DLY_LAST) mem_rd_en = 1'b1;
      R_DATA: if (rready && !rlast && NO_DELAY) begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = r_addr_nxt[ADDR_BITS+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_req   <= '0;
      r_beat  <= 8'd0;
      r_cnt   <= 4'd0;
      r_ok    <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready && arvalid) begin
            r_req   <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
            r_beat  <= 8'd0;
            r_cnt   <= 4'd0;
            r_ok    <= (arsize <= 3'd2);
            rresp   <= (arsize > 3'd2) ? RESP_SLVERR : RESP_OKAY;
            arready <= 1'b0;
            if (NO_DELAY) begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rlast   <= (arlen == 8'd0);
            end else begin
              r_state <= R_WAIT;
            end
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == DLY_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rlast   <= (r_beat == r_req.len);
          end else begin
            r_cnt <= 4'(r_cnt + 4'd1);
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_ok    <= 1'b0;
              arready <= 1'b1;
            end else begin
              r_req.addr <= r_addr_nxt;
              r_beat     <= 8'(r_beat + 8'd1);
              if (NO_DELAY) begin
                rlast <= (8'(r_beat + 8'd1) == r_req.len);
              end else begin
                r_state <= R_WAIT;
                rvalid  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Error bursts are accepted beat by beat but never touch memory
  assign mem_wr_en = (w_state == W_DATA) && wvalid && (w_req.size <= 3'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_req   <= '0;
      w_beat  <= 8'd0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awready && awvalid) begin
            w_req   <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
            w_beat  <= 8'd0;
            bresp   <= (awsize > 3'd2) ? RESP_SLVERR : RESP_OKAY;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_req.addr <= w_addr_nxt;
            w_beat     <= 8'(w_beat + 8'd1);
            if (wlast || (w_beat == w_req.len)) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_sram_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk     (clk),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data),
    .wr_en   (mem_wr_en),
    .wr_addr (w_req.addr[ADDR_BITS+1:2]),
    .wr_data (wdata),
    .wr_strb (wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: two instances (read delay 0 and 2) driven through
// AXI tasks and checked against a word-array model of the memory.
module tb_axi_sram_slave;

  localparam int unsigned DLY0 = 0;
  localparam int unsigned DLY1 = 2;
  localparam int unsigned WORDS = 4096;

  logic clk = 1'b0;
  logic resetn;

  logic [3:0]  arid[2], awid[2], wid[2], rid[2], bid[2];
  logic [31:0] araddr[2], awaddr[2], wdata[2], rdata[2];
  logic [7:0]  arlen[2], awlen[2];
  logic [2:0]  arsize[2], awsize[2], arprot[2], awprot[2];
  logic [1:0]  arburst[2], awburst[2], arlock[2], awlock[2], rresp[2], bresp[2];
  logic [3:0]  arcache[2], awcache[2], wstrb[2];
  logic        arvalid[2], arready[2], rlast[2], rvalid[2], rready[2];
  logic        awvalid[2], awready[2], wlast[2], wvalid[2], wready[2], bvalid[2], bready[2];

  logic [31:0] model_mem [2][WORDS];
  bit          model_vld [2][WORDS];
  logic [31:0] wbuf_data [16];
  logic [3:0]  wbuf_strb [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_sram_slave #(.ADDR_BITS(12), .READ_DELAY(g == 0 ? DLY0 : DLY1)) dut (
      .clk(clk), .resetn(resetn),
      .arid(arid[g]), .araddr(araddr[g]), .arlen(arlen[g]), .arsize(arsize[g]),
      .arburst(arburst[g]), .arlock(arlock[g]), .arcache(arcache[g]), .arprot(arprot[g]),
      .arvalid(arvalid[g]), .arready(arready[g]),
      .rid(rid[g]), .rdata(rdata[g]), .rresp(rresp[g]), .rlast(rlast[g]),
      .rvalid(rvalid[g]), .rready(rready[g]),
      .awid(awid[g]), .awaddr(awaddr[g]), .awlen(awlen[g]), .awsize(awsize[g]),
      .awburst(awburst[g]), .awlock(awlock[g]), .awcache(awcache[g]), .awprot(awprot[g]),
      .awvalid(awvalid[g]), .awready(awready[g]),
      .wid(wid[g]), .wdata(wdata[g]), .wstrb(wstrb[g]), .wlast(wlast[g]),
      .wvalid(wvalid[g]), .wready(wready[g]),
      .bid(bid[g]), .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g])
    );
  end

  function automatic int delay_of(input int d);
    return (d == 0) ? int'(DLY0) : int'(DLY1);
  endfunction

  // Burst address rule: FIXED holds, everything else adds the beat size
  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size,
                                       input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (32'd1 << size);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic init_inputs();
    for (int d = 0; d < 2; d++) begin
      arid[d] = 4'd0; araddr[d] = 32'd0; arlen[d] = 8'd0; arsize[d] = 3'd2; arburst[d] = 2'b01;
      arlock[d] = 2'd0; arcache[d] = 4'd0; arprot[d] = 3'd0; arvalid[d] = 1'b0; rready[d] = 1'b1;
      awid[d] = 4'd0; awaddr[d] = 32'd0; awlen[d] = 8'd0; awsize[d] = 3'd2; awburst[d] = 2'b01;
      awlock[d] = 2'd0; awcache[d] = 4'd0; awprot[d] = 3'd0; awvalid[d] = 1'b0;
      wid[d] = 4'd0; wdata[d] = 32'd0; wstrb[d] = 4'd0; wlast[d] = 1'b0; wvalid[d] = 1'b0;
      bready[d] = 1'b0;
    end
  endtask

  task automatic axi_write(input int d, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int nbeats, input int bstall);
    int cnt;
    int w;
    logic [31:0] a;
    logic [1:0] exp_resp;
    @(negedge clk);
    awvalid[d] = 1'b1; awid[d] = id; awaddr[d] = addr; awlen[d] = len;
    awsize[d] = size; awburst[d] = burst;
    cnt = 0;
    while (!awready[d] && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (!awready[d]) begin n_err++; $display("FAIL aw_timeout dut%0d: awready never rose", d); end
    @(negedge clk);
    awvalid[d] = 1'b0;
    n_cmp++;
    if (wready[d] !== 1'b1) begin
      n_err++; $display("FAIL aw_to_wready dut%0d: got %b want 1", d, wready[d]);
    end
    a = addr;
    exp_resp = (size > 3'd2) ? 2'b10 : 2'b00;
    for (int b = 0; b < nbeats; b++) begin
      wvalid[d] = 1'b1; wdata[d] = wbuf_data[b]; wstrb[d] = wbuf_strb[b];
      wlast[d] = (b == nbeats - 1); wid[d] = 4'($urandom);
      cnt = 0;
      while (!wready[d] && cnt < 20) begin @(negedge clk); cnt++; end
      if (size <= 3'd2) begin
        w = word_of(a);
        for (int i = 0; i < 4; i++)
          if (wbuf_strb[b][i]) model_mem[d][w][8*i +: 8] = wbuf_data[b][8*i +: 8];
        model_vld[d][w] = model_vld[d][w] || (wbuf_strb[b] == 4'hF);
      end
      a = step(a, size, burst);
      @(negedge clk);
    end
    wvalid[d] = 1'b0; wlast[d] = 1'b0;
    n_cmp++;
    if (bvalid[d] !== 1'b1) begin
      n_err++; $display("FAIL b_latency dut%0d: bvalid %b want 1", d, bvalid[d]);
    end
    for (int s = 0; s < bstall; s++) begin
      n_cmp++;
      if (bvalid[d] !== 1'b1 || bid[d] !== id || bresp[d] !== exp_resp || awready[d] !== 1'b0) begin
        n_err++;
        $display("FAIL b_stall dut%0d: bvalid=%b bid=%h bresp=%b awready=%b want 1 %h %b 0",
                 d, bvalid[d], bid[d], bresp[d], awready[d], id, exp_resp);
      end
      @(negedge clk);
    end
    bready[d] = 1'b1;
    n_cmp++;
    if (bid[d] !== id || bresp[d] !== exp_resp) begin
      n_err++; $display("FAIL b_payload dut%0d: bid=%h bresp=%b want %h %b", d, bid[d], bresp[d], id, exp_resp);
    end
    @(negedge clk);
    bready[d] = 1'b0;
    n_cmp++;
    if (bvalid[d] !== 1'b0 || awready[d] !== 1'b1) begin
      n_err++; $display("FAIL b_done dut%0d: bvalid=%b awready=%b want 0 1", d, bvalid[d], awready[d]);
    end
  endtask

  task automatic axi_read(input int d, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_cycles);
    int cnt;
    int w;
    logic [31:0] a;
    logic [31:0] exp_data;
    logic [31:0] held;
    logic [1:0]  exp_resp;
    @(negedge clk);
    arvalid[d] = 1'b1; arid[d] = id; araddr[d] = addr; arlen[d] = len;
    arsize[d] = size; arburst[d] = burst; rready[d] = 1'b1;
    cnt = 0;
    while (!arready[d] && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (!arready[d]) begin n_err++; $display("FAIL ar_timeout dut%0d: arready never rose", d); end
    @(negedge clk);
    arvalid[d] = 1'b0;
    n_cmp++;
    if (arready[d] !== 1'b0) begin n_err++; $display("FAIL ar_busy dut%0d: arready %b want 0", d, arready[d]); end
    a = addr;
    exp_resp = (size > 3'd2) ? 2'b10 : 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      cnt = 0;
      while (!rvalid[d] && cnt < 40) begin @(negedge clk); cnt++; end
      n_cmp++;
      if (rvalid[d] !== 1'b1 || cnt != delay_of(d)) begin
        n_err++; $display("FAIL r_latency dut%0d beat %0d: waited %0d want %0d", d, b, cnt, delay_of(d));
      end
      w = word_of(a);
      exp_data = (size > 3'd2) ? 32'd0 : model_mem[d][w];
      n_cmp++;
      if (rid[d] !== id || rresp[d] !== exp_resp || rlast[d] !== (b == int'(len))) begin
        n_err++;
        $display("FAIL r_ctrl dut%0d beat %0d: rid=%h rresp=%b rlast=%b want %h %b %b",
                 d, b, rid[d], rresp[d], rlast[d], id, exp_resp, (b == int'(len)));
      end
      if (size > 3'd2 || model_vld[d][w]) begin
        n_cmp++;
        if (rdata[d] !== exp_data) begin
          n_err++; $display("FAIL r_data dut%0d beat %0d: got %h want %h", d, b, rdata[d], exp_data);
        end
      end
      if (b == stall_beat) begin
        rready[d] = 1'b0;
        held = rdata[d];
        for (int s = 0; s < stall_cycles; s++) begin
          @(negedge clk);
          n_cmp++;
          if (rvalid[d] !== 1'b1 || rdata[d] !== held || rid[d] !== id ||
              rlast[d] !== (b == int'(len)) || arready[d] !== 1'b0) begin
            n_err++;
            $display("FAIL r_stall dut%0d: rvalid=%b rdata=%h rid=%h arready=%b want 1 %h %h 0",
                     d, rvalid[d], rdata[d], rid[d], arready[d], held, id);
          end
        end
        rready[d] = 1'b1;
      end
      a = step(a, size, burst);
      @(negedge clk);
    end
    n_cmp++;
    if (rvalid[d] !== 1'b0 || arready[d] !== 1'b1) begin
      n_err++; $display("FAIL r_done dut%0d: rvalid=%b arready=%b want 0 1", d, rvalid[d], arready[d]);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (arready[d] !== 1'b0 || awready[d] !== 1'b0 || wready[d] !== 1'b0 || rvalid[d] !== 1'b0 ||
          bvalid[d] !== 1'b0 || rdata[d] !== 32'd0 || rid[d] !== 4'd0 || bid[d] !== 4'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: arready=%b awready=%b wready=%b rvalid=%b bvalid=%b rdata=%h want all 0",
                 d, arready[d], awready[d], wready[d], rvalid[d], bvalid[d], rdata[d]);
      end
    end
    resetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (arready[d] !== 1'b1 || awready[d] !== 1'b1) begin
        n_err++; $display("FAIL reset_release dut%0d: arready=%b awready=%b want 1 1", d, arready[d], awready[d]);
      end
    end
  endtask

  task automatic test_single_read();
    wbuf_data[0] = 32'h1234_5678; wbuf_strb[0] = 4'hF;
    axi_write(0, 4'd1, 32'h10, 8'd0, 3'd2, 2'b01, 1, 0);
    axi_read(0, 4'd3, 32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_partial_strobe();
    wbuf_data[0] = 32'hAAAA_AAAA; wbuf_strb[0] = 4'hF;
    axi_write(0, 4'd6, 32'h8, 8'd0, 3'd2, 2'b01, 1, 0);
    wbuf_data[0] = 32'h1122_3344; wbuf_strb[0] = 4'b0101;
    axi_write(0, 4'd9, 32'h8, 8'd0, 3'd2, 2'b01, 1, 0);
    axi_read(0, 4'd2, 32'h8, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_bursts();
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'(i + 1); wbuf_strb[i] = 4'hF; end
    axi_write(1, 4'd4, 32'h100, 8'd3, 3'd2, 2'b01, 4, 0);
    axi_read(1, 4'd5, 32'h100, 8'd3, 3'd2, 2'b01, -1, 0);
    axi_write(1, 4'd7, 32'h100, 8'd3, 3'd2, 2'b00, 4, 0);
    axi_read(1, 4'd8, 32'h100, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    axi_write(1, 4'hA, 32'h200, 8'd1, 3'd2, 2'b01, 2, 3);
    axi_read(1, 4'hB, 32'h200, 8'd1, 3'd2, 2'b01, 0, 5);
  endtask

  task automatic test_error();
    axi_read(0, 4'd7, 32'h10, 8'd1, 3'd3, 2'b01, -1, 0);
    wbuf_data[0] = 32'hDEAD_BEEF; wbuf_strb[0] = 4'hF;
    axi_write(0, 4'hC, 32'h10, 8'd0, 3'd3, 2'b01, 1, 0);
    axi_read(0, 4'hD, 32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_w_before_aw();
    int cnt;
    @(negedge clk);
    wvalid[0] = 1'b1; wdata[0] = 32'hCAFE_0001; wstrb[0] = 4'hF; wlast[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (wready[0] !== 1'b0) begin n_err++; $display("FAIL w_early dut0: wready %b want 0", wready[0]); end
    end
    awvalid[0] = 1'b1; awid[0] = 4'hE; awaddr[0] = 32'h30; awlen[0] = 8'd0;
    awsize[0] = 3'd2; awburst[0] = 2'b01;
    cnt = 0;
    while (!awready[0] && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (wready[0] !== 1'b0) begin n_err++; $display("FAIL w_at_aw dut0: wready %b want 0", wready[0]); end
    @(negedge clk);
    awvalid[0] = 1'b0;
    n_cmp++;
    if (wready[0] !== 1'b1) begin n_err++; $display("FAIL w_after_aw dut0: wready %b want 1", wready[0]); end
    model_mem[0][word_of(32'h30)] = 32'hCAFE_0001;
    model_vld[0][word_of(32'h30)] = 1'b1;
    @(negedge clk);
    wvalid[0] = 1'b0; wlast[0] = 1'b0;
    n_cmp++;
    if (bvalid[0] !== 1'b1 || bid[0] !== 4'hE) begin
      n_err++; $display("FAIL w_first_b dut0: bvalid=%b bid=%h want 1 e", bvalid[0], bid[0]);
    end
    bready[0] = 1'b1;
    @(negedge clk);
    bready[0] = 1'b0;
    axi_read(0, 4'd1, 32'h30, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_random();
    int d, nb;
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    for (int t = 0; t < 30; t++) begin
      d   = int'($urandom_range(0, 1));
      a   = $urandom;
      len = 8'($urandom_range(0, 7));
      sz  = 3'($urandom_range(0, 3));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(len) + 1)) : int'(len) + 1;
      for (int i = 0; i < 16; i++) begin
        wbuf_data[i] = $urandom;
        wbuf_strb[i] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      end
      axi_write(d, 4'($urandom), a, len, sz, 2'($urandom), nb, int'($urandom_range(0, 2)));
      axi_read(d, 4'($urandom), a, 8'(nb - 1), ($urandom_range(0, 5) == 0) ? 3'd3 : 3'd2,
               2'b01, int'($urandom_range(0, 8)), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    logic [31:0] exp;
    @(negedge clk);
    arvalid[1] = 1'b1; arid[1] = 4'd5; araddr[1] = 32'h100; arlen[1] = 8'd3;
    arsize[1] = 3'd2; arburst[1] = 2'b01; rready[1] = 1'b1;
    cnt = 0;
    while (!arready[1] && cnt < 20) begin @(negedge clk); cnt++; end
    @(negedge clk);
    arvalid[1] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      cnt = 0;
      while (!rvalid[1] && cnt < 40) begin @(negedge clk); cnt++; end
      if (b < 2) @(negedge clk);
    end
    exp = model_mem[1][word_of(32'h108)];
    n_cmp++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== exp) begin
      n_err++; $display("FAIL rst_beat2 dut1: rvalid=%b rdata=%h want 1 %h", rvalid[1], rdata[1], exp);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (rvalid[1] !== 1'b0 || arready[1] !== 1'b0 || awready[1] !== 1'b0 || rdata[1] !== 32'd0) begin
      n_err++;
      $display("FAIL rst_async dut1: rvalid=%b arready=%b awready=%b rdata=%h want 0 0 0 0",
               rvalid[1], arready[1], awready[1], rdata[1]);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (arready[1] !== 1'b1 || awready[1] !== 1'b1) begin
      n_err++; $display("FAIL rst_recover dut1: arready=%b awready=%b want 1 1", arready[1], awready[1]);
    end
    axi_read(1, 4'd6, 32'h100, 8'd3, 3'd2, 2'b01, -1, 0);
    axi_read(0, 4'd3, 32'h8, 8'd0, 3'd2, 2'b01, -1, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < int'(WORDS); i++) begin model_mem[d][i] = 32'd0; model_vld[d][i] = 1'b0; end
    test_reset();
    test_single_read();
    test_partial_strobe();
    test_bursts();
    test_backpressure();
    test_error();
    test_w_before_aw();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
